// File: rtl/frame_ram_arbiter.sv
// Arbitrates the single-port image RAM between the VGA fetch path and the decryptor.
// Define ARB_STATS_EN to add the grant/stall statistics counters.
module frame_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 10000,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_25Mhz,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              dec_req,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_wdata,
    output logic              dec_gnt,
    output logic              dec_rvalid,
    output logic [DATA_W-1:0] dec_rdata,
    output logic              dec_err,
`ifdef ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_vga_cnt,
    output logic [15:0]       stat_dec_cnt,
    output logic [15:0]       stat_stall_cnt,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [SC_W-1:0]   SC_MAX  = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, VGA_RD, DEC_RD} own_t;

    own_t              own_q, own_d;
    logic              oor_q;
    logic [SC_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              vga_in_range, dec_in_range, sel_in_range;

    assign vga_in_range = vga_addr < DEPTH_A;
    assign dec_in_range = dec_addr < DEPTH_A;
    assign sel_in_range = vga_gnt ? vga_in_range : dec_in_range;

    // Grants are suppressed during reset so nothing reaches the RAM.
    always_comb begin
        vga_gnt = 1'b0;
        dec_gnt = 1'b0;
        if (!rst) begin
            if (dec_req && (!vga_req || starve_cnt == SC_MAX))
                dec_gnt = 1'b1;
            else if (vga_req)
                vga_gnt = 1'b1;
        end
    end

    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = rst ? '0 : dec_wdata;
        if (rst)
            ram_addr = '0;
        else if (vga_gnt)
            ram_addr = vga_addr;
        else if (dec_gnt) begin
            ram_addr = dec_addr;
            ram_we   = dec_we && dec_in_range;
        end
    end

    always_comb begin
        own_d = IDLE;
        if (vga_gnt)
            own_d = VGA_RD;
        else if (dec_gnt && !dec_we)
            own_d = DEC_RD;
    end

    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            own_q      <= IDLE;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            starve_cnt <= '0;
            dec_err    <= 1'b0;
        end else begin
            own_q   <= own_d;
            oor_q   <= !sel_in_range;
            dec_err <= dec_gnt && !dec_in_range;
            if (vga_gnt || dec_gnt)
                addr_q <= ram_addr;
            if (!dec_req || dec_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != SC_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Second return stage: capture RAM data for the owner recorded one cycle earlier.
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            vga_valid  <= 1'b0;
            dec_rvalid <= 1'b0;
            vga_data   <= '0;
            dec_rdata  <= '0;
        end else begin
            vga_valid  <= own_q == VGA_RD;
            dec_rvalid <= own_q == DEC_RD;
            if (own_q == VGA_RD)
                vga_data <= oor_q ? '0 : ram_rdata;
            if (own_q == DEC_RD)
                dec_rdata <= oor_q ? '0 : ram_rdata;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk_25Mhz) begin
        if (rst || stat_clr) begin
            stat_vga_cnt   <= '0;
            stat_dec_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (vga_gnt && stat_vga_cnt != 16'hFFFF)
                stat_vga_cnt <= stat_vga_cnt + 16'd1;
            if (dec_gnt && stat_dec_cnt != 16'hFFFF)
                stat_dec_cnt <= stat_dec_cnt + 16'd1;
            if (dec_req && !dec_gnt && stat_stall_cnt != 16'hFFFF)
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
